// File: rtl/i2s_sender_fifo.sv
// I2S/TDM audio transmitter with an internal frame FIFO, programmable bit-clock
// divider, half-rate frame repeat, drain-on-end sequencing and sticky
// underrun/overflow flags. Everything runs in the in_clk domain.
module i2s_sender_fifo #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BCK_DIV    = 4
) (
  input  logic                           in_clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0]   in_data,
  output logic                           in_ready,
  input  logic                           audio_start,
  input  logic                           audio_end,
  input  logic                           rate_half,
  output logic                           audio_req_mode_out,
  output logic                           audio_req_tick,
  output logic                           underrun,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           bck,
  output logic                           lrck,
  output logic                           sout
);

  localparam int S    = (CHANNELS < 2) ? 2 : CHANNELS;
  localparam int HALF = BCK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BITW = $clog2(SLOT_W);
  localparam int SLW  = $clog2(S);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int WW   = CHANNELS * SAMPLE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [DW-1:0]   div;
  logic            div_wrap;
  logic            fall;
  logic            frame_fall;
  logic [BITW-1:0] bit_idx;
  logic [SLW-1:0]  slot_idx;
  logic            bit_last;
  logic            slot_last;

  logic            start_pend;
  logic            repeat_pend;
  logic            start_eff;
  logic            play;
  logic            pop;
  logic            replay;
  logic            zero_load;
  logic            push;

  logic [WW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [WW-1:0]   head;

  logic [WW-1:0]   frame_reg;
  logic [WW-1:0]   src_word;
  logic [WW-1:0]   shifted;
  logic [SLW-1:0]  ch;
  int unsigned     shamt;
  logic            sout_bit;
  logic            lrck_bit;

  // Bit-clock timing and frame position decode.
  assign div_wrap   = (div == DW'(HALF - 1));
  assign fall       = div_wrap && bck;
  assign bit_last   = (bit_idx == BITW'(SLOT_W - 1));
  assign slot_last  = (slot_idx == SLW'(S - 1));
  assign frame_fall = fall && (bit_idx == '0) && (slot_idx == '0);

  assign start_eff  = audio_start && !audio_end;
  assign push       = in_valid && in_ready;
  assign in_ready   = (level < LW'(FIFO_DEPTH));
  assign fifo_level = level;
  assign head       = mem[rd_ptr];
  assign audio_req_mode_out = (state == RUN);

  // Divider: bck toggles every HALF in_clk cycles, low out of reset.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      div <= '0;
      bck <= 1'b0;
    end else if (div_wrap) begin
      div <= '0;
      bck <= ~bck;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Free-running position counter; holds the bit to be driven at the next fall.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      bit_idx  <= '0;
      slot_idx <= '0;
    end else if (fall) begin
      if (bit_last) begin
        bit_idx  <= '0;
        slot_idx <= slot_last ? '0 : slot_idx + 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Playback state register.
  always_ff @(posedge in_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and frame-load decisions, evaluated at frame boundaries.
  always_comb begin
    next_state = state;
    play       = 1'b0;
    case (state)
      IDLE: begin
        if (!audio_end && start_pend && frame_fall) begin
          next_state = RUN;
          play       = 1'b1;
        end
      end
      RUN: begin
        if (audio_end) next_state = DRAIN;
        play = frame_fall;
      end
      DRAIN: begin
        if (start_eff) begin
          next_state = RUN;
          play       = frame_fall;
        end else if (frame_fall) begin
          if ((level == '0) && !repeat_pend) next_state = IDLE;
          else                               play       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    replay    = play && repeat_pend;
    pop       = play && !repeat_pend && (level != '0);
    zero_load = play && !repeat_pend && (level == '0);
  end

  // Start request held in IDLE until the next frame boundary; end cancels it.
  always_ff @(posedge in_clk) begin
    if (reset)                              start_pend <= 1'b0;
    else if (audio_end)                     start_pend <= 1'b0;
    else if (state == IDLE && audio_start)  start_pend <= 1'b1;
    else if (state != IDLE)                 start_pend <= 1'b0;
  end

  // Half-rate repeat: sampled at each pop, consumed by the replayed frame.
  always_ff @(posedge in_clk) begin
    if (reset)                     repeat_pend <= 1'b0;
    else if (pop)                  repeat_pend <= rate_half;
    else if (replay || zero_load)  repeat_pend <= 1'b0;
  end

  // FIFO storage (no reset needed: pointers and level define validity).
  always_ff @(posedge in_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Serial bit select; the new word is used directly on the boundary fall so
  // its MSB goes out on the same fall that loads it.
  always_comb begin
    src_word = frame_reg;
    if (pop)            src_word = head;
    else if (zero_load) src_word = '0;
    ch       = (CHANNELS == 1) ? '0 : slot_idx;
    shamt    = int'(ch) * SAMPLE_W + int'(bit_idx);
    shifted  = src_word << shamt;
    sout_bit = (int'(bit_idx) < SAMPLE_W) ? shifted[WW-1] : 1'b0;
    lrck_bit = ((slot_idx >= SLW'(S / 2)) ||
                ((slot_idx == SLW'(S / 2 - 1)) && bit_last)) &&
               !(slot_last && bit_last);
  end

  // Registered serial outputs, frame word hold and refill tick.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      sout           <= 1'b0;
      lrck           <= 1'b0;
      frame_reg      <= '0;
      audio_req_tick <= 1'b0;
    end else begin
      audio_req_tick <= pop;
      if (play) frame_reg <= src_word;
      if (fall) begin
        lrck <= lrck_bit;
        sout <= (next_state == IDLE) ? 1'b0 : sout_bit;
      end
    end
  end

  // Sticky status flags; a new error in the same cycle as a start is kept.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_eff) begin
        underrun <= 1'b0;
        overflow <= 1'b0;
      end
      if (zero_load)              underrun <= 1'b1;
      if (in_valid && !in_ready)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_sender_fifo.sv
// Directed bench for i2s_sender_fifo: stereo instance plus a mono instance,
// with a frame capture monitor aligned to the bit-clock falls.
module tb_i2s_sender_fifo;

  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

  logic        in_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        audio_start = 1'b0;
  logic        audio_end = 1'b0;
  logic        rate_half = 1'b0;
  logic        mode, tick, underrun, overflow;
  logic [2:0]  fifo_level;
  logic        bck, lrck, sout;

  logic        m_valid = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_ready;
  logic        m_start = 1'b0;
  logic        m_mode, m_tick, m_underrun, m_overflow;
  logic [2:0]  m_level;
  logic        m_bck, m_lrck, m_sout;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 in_clk = ~in_clk;

  i2s_sender_fifo #(
    .SAMPLE_W(16), .SLOT_W(32), .CHANNELS(2), .FIFO_DEPTH(4), .BCK_DIV(4)
  ) u_dut (
    .in_clk(in_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .audio_start(audio_start), .audio_end(audio_end),
    .rate_half(rate_half), .audio_req_mode_out(mode), .audio_req_tick(tick),
    .underrun(underrun), .overflow(overflow), .fifo_level(fifo_level),
    .bck(bck), .lrck(lrck), .sout(sout)
  );

  i2s_sender_fifo #(
    .SAMPLE_W(16), .SLOT_W(32), .CHANNELS(1), .FIFO_DEPTH(4), .BCK_DIV(4)
  ) u_mono (
    .in_clk(in_clk), .reset(reset), .in_valid(m_valid), .in_data(m_data),
    .in_ready(m_ready), .audio_start(m_start), .audio_end(1'b0),
    .rate_half(1'b0), .audio_req_mode_out(m_mode), .audio_req_tick(m_tick),
    .underrun(m_underrun), .overflow(m_overflow), .fifo_level(m_level),
    .bck(m_bck), .lrck(m_lrck), .sout(m_sout)
  );

  // Capture monitor: one 64-bit word per frame, MSB = bit driven at b==0.
  logic        prev_bck;
  int          nfall, cyc, tick_bad, mon_b;
  logic [63:0] cur_s, cur_l, cur_m;
  logic [63:0] s_q[$];
  logic [63:0] l_q[$];
  logic [63:0] m_q[$];
  int          tick_q[$];

  always @(negedge in_clk) begin
    if (reset) begin
      prev_bck = 1'b0;
      nfall = 0;
      cyc = 0;
      tick_bad = 0;
      s_q.delete();
      l_q.delete();
      m_q.delete();
      tick_q.delete();
    end else begin
      cyc++;
      if (prev_bck && !bck) begin
        mon_b = nfall % 64;
        cur_s[63-mon_b] = sout;
        cur_l[63-mon_b] = lrck;
        cur_m[63-mon_b] = m_sout;
        if (tick && mon_b != 0) tick_bad++;
        nfall++;
        if (mon_b == 63) begin
          s_q.push_back(cur_s);
          l_q.push_back(cur_l);
          m_q.push_back(cur_m);
        end
      end else if (tick) begin
        tick_bad++;
      end
      if (tick) tick_q.push_back(cyc);
      prev_bck = bck;
    end
  end

  function automatic logic [63:0] exp_frame(input logic [31:0] w);
    return {w[31:16], 16'h0000, w[15:0], 16'h0000};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; audio_start = 1'b0; audio_end = 1'b0; rate_half = 1'b0;
    m_valid = 1'b0; m_start = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data = w;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    audio_start = 1'b1;
    step(1);
    audio_start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (s_q.size() < n && k < 300 * n + 600) begin
      step(1);
      k++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] pat;
    do_reset();
    step(8);
    pulse_start();
    for (int i = 0; i < 5; i++) push(32'h1000_0001 + i);
    wait_frames(1);
    step(40);
    reset = 1'b1;
    step(1);
    n_cmp++;
    if ({bck, lrck, sout, tick, mode} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got bck/lrck/sout/tick/mode=%b want 00000", {bck, lrck, sout, tick, mode});
    end
    n_cmp++;
    if (fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if ({underrun, overflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00", {underrun, overflow});
    end
    reset = 1'b0;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      pat = {pat[6:0], bck};
    end
    n_cmp++;
    if (pat !== 8'b0110_0110) begin
      n_fail++; $display("FAIL reset_bck_period: got %b want 01100110", pat);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(8);
    push(32'hD999_9991);
    push(32'h1234_5678);
    pulse_start();
    wait_frames(3);
    n_cmp++;
    if (s_q.size() < 3) begin
      n_fail++; $display("FAIL basic_timeout: got %0d frames want 3", s_q.size());
    end
    n_cmp++;
    if (s_q[0] !== 64'h0) begin
      n_fail++; $display("FAIL basic_idle_frame: got %h want 0", s_q[0]);
    end
    n_cmp++;
    if (s_q[1] !== 64'hD999_0000_9991_0000) begin
      n_fail++; $display("FAIL basic_frame1: got %h want d999000099910000", s_q[1]);
    end
    n_cmp++;
    if (s_q[2] !== 64'h1234_0000_5678_0000) begin
      n_fail++; $display("FAIL basic_frame2: got %h want 1234000056780000", s_q[2]);
    end
    n_cmp++;
    if (l_q[1] !== LR_EXP) begin
      n_fail++; $display("FAIL basic_lrck: got %h want %h", l_q[1], LR_EXP);
    end
    n_cmp++;
    if (tick_q.size() !== 2 || tick_bad !== 0) begin
      n_fail++; $display("FAIL basic_ticks: got %0d ticks %0d misplaced want 2 and 0", tick_q.size(), tick_bad);
    end
    n_cmp++;
    if (tick_q.size() >= 2 && (tick_q[1] - tick_q[0]) !== 256) begin
      n_fail++; $display("FAIL basic_tick_gap: got %0d want 256", tick_q[1] - tick_q[0]);
    end
    n_cmp++;
    if ({mode, underrun, fifo_level} !== 5'b10_000) begin
      n_fail++; $display("FAIL basic_status: got mode/underrun/level=%b want 10000", {mode, underrun, fifo_level});
    end
  endtask

  task automatic test_half_rate();
    logic [31:0] hw [3];
    hw[0] = 32'hA5A5_0F0F;
    hw[1] = 32'h8001_7FFE;
    hw[2] = 32'hFFFF_0001;
    do_reset();
    step(8);
    rate_half = 1'b1;
    for (int i = 0; i < 3; i++) push(hw[i]);
    pulse_start();
    wait_frames(7);
    n_cmp++;
    if (s_q.size() < 7) begin
      n_fail++; $display("FAIL half_timeout: got %0d frames want 7", s_q.size());
    end
    for (int i = 1; i < 7; i++) begin
      n_cmp++;
      if (s_q[i] !== exp_frame(hw[(i-1)/2])) begin
        n_fail++; $display("FAIL half_frame%0d: got %h want %h", i, s_q[i], exp_frame(hw[(i-1)/2]));
      end
    end
    n_cmp++;
    if (tick_q.size() !== 3) begin
      n_fail++; $display("FAIL half_tick_count: got %0d want 3", tick_q.size());
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (tick_q.size() > i && (tick_q[i] - tick_q[i-1]) !== 512) begin
        n_fail++; $display("FAIL half_tick_gap%0d: got %0d want 512", i, tick_q[i] - tick_q[i-1]);
      end
    end
    rate_half = 1'b0;
  endtask

  task automatic test_underrun();
    do_reset();
    step(8);
    pulse_start();
    wait_frames(1);
    step(8);
    n_cmp++;
    if ({mode, underrun} !== 2'b11) begin
      n_fail++; $display("FAIL under_set: got mode/underrun=%b want 11", {mode, underrun});
    end
    push(32'h0F0F_F0F0);
    wait_frames(3);
    n_cmp++;
    if (s_q.size() < 3 || s_q[1] !== 64'h0) begin
      n_fail++; $display("FAIL under_zero_frame: got %h want 0", s_q[1]);
    end
    n_cmp++;
    if (s_q[2] !== 64'h0F0F_0000_F0F0_0000) begin
      n_fail++; $display("FAIL under_data_frame: got %h want 0f0f0000f0f00000", s_q[2]);
    end
    n_cmp++;
    if (underrun !== 1'b1 || tick_q.size() !== 1) begin
      n_fail++; $display("FAIL under_sticky: got underrun=%b ticks=%0d want 1 and 1", underrun, tick_q.size());
    end
    pulse_start();
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_fail++; $display("FAIL under_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(8);
    for (int i = 0; i < 5; i++) push(32'h1111_2222 * (i + 1));
    n_cmp++;
    if ({fifo_level, in_ready, overflow} !== 5'b100_0_1) begin
      n_fail++; $display("FAIL ovf_state: got level/ready/ovf=%b want 10001", {fifo_level, in_ready, overflow});
    end
    pulse_start();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    wait_frames(6);
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (s_q[i] !== exp_frame(32'h1111_2222 * i)) begin
        n_fail++; $display("FAIL ovf_frame%0d: got %h want %h", i, s_q[i], exp_frame(32'h1111_2222 * i));
      end
    end
    n_cmp++;
    if (s_q.size() < 6 || s_q[5] !== 64'h0) begin
      n_fail++; $display("FAIL ovf_dropped: got %h want 0", s_q[5]);
    end
  endtask

  task automatic test_drain();
    do_reset();
    step(8);
    push(32'hCAFE_BABE);
    push(32'h0123_4567);
    push(32'h89AB_CDEF);
    pulse_start();
    wait_frames(1);
    step(8);
    audio_end = 1'b1;
    step(1);
    audio_end = 1'b0;
    n_cmp++;
    if ({mode, fifo_level} !== 4'b0_010) begin
      n_fail++; $display("FAIL drain_entry: got mode/level=%b want 0010", {mode, fifo_level});
    end
    wait_frames(5);
    n_cmp++;
    if (s_q.size() < 5) begin
      n_fail++; $display("FAIL drain_timeout: got %0d frames want 5", s_q.size());
    end
    n_cmp++;
    if (s_q[1] !== exp_frame(32'hCAFE_BABE) || s_q[2] !== exp_frame(32'h0123_4567) ||
        s_q[3] !== exp_frame(32'h89AB_CDEF)) begin
      n_fail++; $display("FAIL drain_frames: got %h %h %h want cafe/0123/89ab frames", s_q[1], s_q[2], s_q[3]);
    end
    n_cmp++;
    if (s_q[4] !== 64'h0 || l_q[4] !== LR_EXP) begin
      n_fail++; $display("FAIL drain_idle: got sout %h lrck %h want 0 and %h", s_q[4], l_q[4], LR_EXP);
    end
    n_cmp++;
    if ({mode, underrun} !== 2'b00 || tick_q.size() !== 3) begin
      n_fail++; $display("FAIL drain_status: got mode/underrun=%b ticks=%0d want 00 and 3", {mode, underrun}, tick_q.size());
    end
  endtask

  task automatic test_mono();
    do_reset();
    step(8);
    m_valid = 1'b1;
    m_data = 16'hC3A5;
    step(1);
    m_valid = 1'b0;
    m_start = 1'b1;
    step(1);
    m_start = 1'b0;
    wait_frames(2);
    n_cmp++;
    if (m_q.size() < 2 || m_q[0] !== 64'h0) begin
      n_fail++; $display("FAIL mono_idle: got %h want 0", m_q[0]);
    end
    n_cmp++;
    if (m_q[1] !== 64'hC3A5_0000_C3A5_0000) begin
      n_fail++; $display("FAIL mono_dup: got %h want c3a50000c3a50000", m_q[1]);
    end
    n_cmp++;
    if ({m_mode, m_underrun, m_level} !== 5'b10_000) begin
      n_fail++; $display("FAIL mono_status: got %b want 10000", {m_mode, m_underrun, m_level});
    end
  endtask

  initial begin
    step(1);
    test_reset();
    test_basic();
    test_half_rate();
    test_underrun();
    test_overflow();
    test_drain();
    test_mono();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
